// File: rtl/map_probe_sequencer.sv
// Collision probe sequencer: shares one single-port map ROM between the eight
// Mario collision probes (two above, two below, two left, two right).
// On start it issues the eight ROM lookups back-to-back, one per cycle. It
// captures and classifies the returned tile IDs, then publishes registered
// contact flags, a coin-bump pulse and a done strobe.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      request a probe sweep (sampled only when idle)
//   map_base   map column of the view's left edge
//   scroll_px  pixel offset of the view within the first tile
//   mario_x    Mario screen x (pixels)
//   mario_y    Mario screen y (pixels)
//   rom_addr   map ROM address (registered)
//   rom_data   map ROM tile ID, valid one cycle after rom_addr
//   busy       sweep in progress
//   done       one-cycle pulse when the flags update
//   blk_above  solid tile above the head
//   blk_below  solid tile under the feet
//   blk_left   wall to the left
//   blk_right  wall to the right
//   coin_bump  one-cycle pulse with done: an above probe read tile 0
module map_probe_sequencer #(
   parameter int unsigned ROW_STRIDE = 212,
   parameter int unsigned MAP_ROWS   = 13,
   parameter logic [5:0]  EMPTY_ID   = 6'd63
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [11:0] map_base,
   input  logic [5:0]  scroll_px,
   input  logic [10:0] mario_x,
   input  logic [9:0]  mario_y,
   output logic [11:0] rom_addr,
   input  logic [5:0]  rom_data,
   output logic        busy,
   output logic        done,
   output logic        blk_above,
   output logic        blk_below,
   output logic        blk_left,
   output logic        blk_right,
   output logic        coin_bump
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESOLVE} state_t;

   typedef struct packed {
      logic [11:0] addr;
      logic        solid;   // forced to tile 0 (head at top edge / px at 0)
      logic        empty;   // row beyond the map, read as EMPTY_ID
   } probe_t;

   // Geometry of probe k: pixel row/col -> tile row/col -> wrapped address.
   function automatic probe_t probe_calc(input logic [11:0] b, input logic [11:0] p,
                                         input logic [9:0] y, input logic [2:0] k);
      probe_t      r;
      logic [10:0] rpix;
      logic [12:0] cpix;
      logic [4:0]  row;
      logic [6:0]  col;
      case (k)
         3'd0, 3'd1: rpix = {1'b0, y} - 11'd1;
         3'd2, 3'd3: rpix = {1'b0, y} + 11'd64;
         3'd4, 3'd6: rpix = {1'b0, y};
         default:    rpix = {1'b0, y} + 11'd63;
      endcase
      case (k)
         3'd0, 3'd2: cpix = {1'b0, p};
         3'd1, 3'd3: cpix = {1'b0, p} + 13'd63;
         3'd4, 3'd5: cpix = {1'b0, p} - 13'd1;
         default:    cpix = {1'b0, p} + 13'd64;
      endcase
      row    = 5'(rpix >> 6);
      col    = 7'(cpix >> 6);
      r.addr = b + 12'(ROW_STRIDE) * {7'd0, row} + {5'd0, col};
      r.solid = ((k == 3'd0 || k == 3'd1) && y == '0) ||
                ((k == 3'd4 || k == 3'd5) && p == '0);
      r.empty = 32'(row) >= MAP_ROWS;
      return r;
   endfunction

   function automatic logic in_above(input logic [5:0] t);
      return t inside {6'd0, 6'd1, 6'd2};
   endfunction

   function automatic logic in_below(input logic [5:0] t);
      return t inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd13, 6'd38, 6'd39};
   endfunction

   function automatic logic in_left(input logic [5:0] t);
      return t inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd13, 6'd39, 6'd49};
   endfunction

   function automatic logic in_right(input logic [5:0] t);
      return t inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd13, 6'd38, 6'd48};
   endfunction

   state_t      state;
   logic [2:0]  cnt;
   logic [11:0] base_q;
   logic [11:0] px_q;
   logic [9:0]  y_q;
   logic [5:0]  tile [8];

   logic [11:0] px_in;
   logic [2:0]  cap_k;
   probe_t      first_pr;
   probe_t      next_pr;
   probe_t      cap_pr;
   logic [5:0]  cap_tile;
   logic [5:0]  fin [8];
   logic        above_n, below_n, left_n, right_n, coin_n;

   always_comb begin
      px_in    = {1'b0, mario_x} + {6'd0, scroll_px};
      // Probe k is captured one cycle after it was addressed.
      cap_k    = (state == DRAIN) ? 3'd7 : cnt - 3'd1;
      first_pr = probe_calc(map_base, px_in, mario_y, 3'd0);
      next_pr  = probe_calc(base_q, px_q, y_q, cnt + 3'd1);
      cap_pr   = probe_calc(base_q, px_q, y_q, cap_k);
      if (cap_pr.solid)
         cap_tile = '0;
      else if (cap_pr.empty)
         cap_tile = EMPTY_ID;
      else
         cap_tile = rom_data;

      // Flags resolve in DRAIN using probe 7 straight off the ROM bus.
      for (int unsigned i = 0; i < 8; i++)
         fin[i] = tile[i];
      fin[7] = cap_tile;

      above_n = in_above(fin[0]) | in_above(fin[1]);
      below_n = in_below(fin[2]) | in_below(fin[3]);
      left_n  = in_left(fin[4])  | in_left(fin[5]);
      right_n = in_right(fin[6]) | in_right(fin[7]);
      // With y != 0 a zero on P0/P1 can only come from a real ROM read.
      coin_n  = (y_q != '0) && (fin[0] == '0 || fin[1] == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         base_q    <= '0;
         px_q      <= '0;
         y_q       <= '0;
         rom_addr  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         coin_bump <= 1'b0;
         blk_above <= 1'b0;
         blk_below <= 1'b0;
         blk_left  <= 1'b0;
         blk_right <= 1'b0;
         for (int unsigned i = 0; i < 8; i++)
            tile[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               done      <= 1'b0;
               coin_bump <= 1'b0;
               if (start) begin
                  base_q   <= map_base;
                  px_q     <= px_in;
                  y_q      <= mario_y;
                  rom_addr <= first_pr.addr;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (cnt != '0)
                  tile[cap_k] <= cap_tile;
               if (cnt == 3'd7)
                  state <= DRAIN;
               else
                  rom_addr <= next_pr.addr;
               cnt <= cnt + 3'd1;
            end
            DRAIN: begin
               tile[7]   <= cap_tile;
               blk_above <= above_n;
               blk_below <= below_n;
               blk_left  <= left_n;
               blk_right <= right_n;
               coin_bump <= coin_n;
               done      <= 1'b1;
               state     <= RESOLVE;
            end
            RESOLVE: begin
               done      <= 1'b0;
               coin_bump <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
